// File: rtl/pwm_carrier_multi_pkg.sv
// Shared definitions for the multi-channel PWM carrier generator:
// default widths, mode/enable encodings and a mode-normalising helper.
package pwm_carrier_multi_pkg;

    localparam int DIVCLK_WIDTH   = 5;
    localparam int PWMCOUNT_WIDTH = 16;
    localparam int INTCOUNT_WIDTH = 3;

    typedef enum logic [1:0] {
        COUNT_UP     = 2'b00,
        COUNT_DOWN   = 2'b01,
        COUNT_UPDOWN = 2'b10
    } count_mode_t;

    typedef enum logic [1:0] {
        NO_MASK     = 2'b00,
        MIN_MASK    = 2'b01,
        MAX_MASK    = 2'b10,
        MINMAX_MASK = 2'b11
    } mask_mode_t;

    typedef enum logic { CARR_OFF   = 1'b0, CARR_ON   = 1'b1 } carr_onoff_t;
    typedef enum logic { CLKDIV_OFF = 1'b0, CLKDIV_ON = 1'b1 } clkdiv_onoff_t;
    typedef enum logic { INT_OFF    = 1'b0, INT_ON    = 1'b1 } int_onoff_t;

    // The unused encoding 2'b11 counts like COUNT_UP.
    function automatic count_mode_t norm_mode(input logic [1:0] mode);
        case (mode)
            2'b01:   return COUNT_DOWN;
            2'b10:   return COUNT_UPDOWN;
            default: return COUNT_UP;
        endcase
    endfunction

endpackage

// File: rtl/pwm_carrier_chan.sv
// One carrier channel: counter and direction, shadow/active period and mode,
// min/max event generation with masked commit, and interrupt decimation.
module pwm_carrier_chan
    import pwm_carrier_multi_pkg::*;
#(
    parameter int W  = PWMCOUNT_WIDTH,
    parameter int IW = INTCOUNT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_tick,
    input  logic          i_carr_on,
    input  logic [1:0]    i_count_mode,
    input  logic [1:0]    i_mask_mode,
    input  logic [W-1:0]  i_period,
    input  logic [W-1:0]  i_init,
    input  logic          i_int_on,
    input  logic [IW-1:0] i_int_count,
    output logic [W-1:0]  o_carr,
    output logic          o_dir,
    output logic          o_min,
    output logic          o_max,
    output logic          o_update,
    output logic          o_int
);

    logic [W-1:0]  r_carr;
    logic          r_dir;
    logic          r_min;
    logic          r_max;
    logic          r_update;
    logic          r_int;
    logic [W-1:0]  r_per_act;
    count_mode_t   r_mode_act;
    logic [IW-1:0] r_int_cnt;
    logic          r_started;

    count_mode_t   w_in_mode;
    mask_mode_t    w_mask;
    logic [W-1:0]  w_held;
    logic          w_held_dir;
    logic [W-1:0]  w_c;
    logic          w_d;
    logic [W-1:0]  w_p;
    count_mode_t   w_mode;
    logic [W-1:0]  w_inc;
    logic [W-1:0]  w_dec;
    logic [W-1:0]  w_next_carr;
    logic          w_next_dir;
    logic          w_ev_min;
    logic          w_ev_max;
    logic          w_upd_ev;
    logic          w_commit_dir;
    logic          w_load_act;

    assign w_in_mode  = norm_mode(i_count_mode);
    assign w_mask     = mask_mode_t'(i_mask_mode);
    assign w_held     = (i_init < i_period) ? i_init : i_period;
    assign w_held_dir = (w_in_mode == COUNT_DOWN);

    // Before the first tick the held value is the starting point. With
    // NO_MASK the commit happens on this very tick ahead of the step, so the
    // shadow values drive the step; otherwise the active ones do.
    assign w_c    = r_started ? r_carr : w_held;
    assign w_d    = r_started ? r_dir  : w_held_dir;
    assign w_p    = (r_started && (w_mask != NO_MASK)) ? r_per_act  : i_period;
    assign w_mode = (r_started && (w_mask != NO_MASK)) ? r_mode_act : w_in_mode;
    assign w_inc  = w_c + 1'b1;
    assign w_dec  = w_c - 1'b1;

    // Next count, direction and min/max events for one tick.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_next_carr = w_c;
        w_next_dir  = w_d;
        w_ev_min    = 1'b0;
        w_ev_max    = 1'b0;
        if (w_p == '0) begin
            w_next_carr = '0;
            w_next_dir  = (w_mode == COUNT_DOWN);
            w_ev_min    = 1'b1;
            w_ev_max    = 1'b1;
        end else begin
            case (w_mode)
                COUNT_DOWN: begin
                    w_next_dir = 1'b1;
                    if (w_c == '0 || w_c > w_p) begin
                        w_next_carr = w_p;
                        w_ev_max    = 1'b1;
                    end else begin
                        w_next_carr = w_dec;
                        w_ev_min    = (w_dec == '0);
                    end
                end
                COUNT_UPDOWN: begin
                    if (w_c > w_p) begin
                        w_next_carr = '0;
                        w_next_dir  = 1'b0;
                        w_ev_min    = 1'b1;
                    end else if (!w_d) begin
                        if (w_c == w_p) begin
                            w_next_carr = w_dec;
                            w_next_dir  = 1'b1;
                        end else begin
                            w_next_carr = w_inc;
                            w_ev_max    = (w_inc == w_p);
                            w_next_dir  = (w_inc == w_p);
                        end
                    end else begin
                        if (w_c == '0) begin
                            w_next_carr = w_inc;
                            w_next_dir  = 1'b0;
                        end else begin
                            w_next_carr = w_dec;
                            w_ev_min    = (w_dec == '0);
                            w_next_dir  = (w_dec != '0);
                        end
                    end
                end
                default: begin
                    w_next_dir = 1'b0;
                    if (w_c >= w_p) begin
                        w_next_carr = '0;
                        w_ev_min    = 1'b1;
                    end else begin
                        w_next_carr = w_inc;
                        w_ev_max    = (w_inc == w_p);
                    end
                end
            endcase
        end
    end

    // Update event selection by mask mode.
    always_comb begin
        w_upd_ev = 1'b0;
        case (w_mask)
            NO_MASK:     w_upd_ev = 1'b1;
            MIN_MASK:    w_upd_ev = w_ev_min;
            MAX_MASK:    w_upd_ev = w_ev_max;
            MINMAX_MASK: w_upd_ev = w_ev_min | w_ev_max;
            default:     w_upd_ev = 1'b0;
        endcase
    end

    // A committed fixed-direction mode pins o_dir; UPDOWN restarts upward at 0.
    assign w_commit_dir = (w_in_mode == COUNT_DOWN)   ? 1'b1 :
                          (w_in_mode == COUNT_UPDOWN) ? ((w_next_carr == '0) ? 1'b0 : w_next_dir) :
                          1'b0;
    assign w_load_act   = !r_started || w_upd_ev;

    // Counter, direction, active registers and event strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_carr     <= '0;
            r_dir      <= 1'b0;
            r_min      <= 1'b0;
            r_max      <= 1'b0;
            r_update   <= 1'b0;
            r_per_act  <= '0;
            r_mode_act <= COUNT_UP;
            r_started  <= 1'b0;
        end else if (i_carr_on == CARR_OFF) begin
            r_carr     <= w_held;
            r_dir      <= w_held_dir;
            r_min      <= 1'b0;
            r_max      <= 1'b0;
            r_update   <= 1'b0;
            r_per_act  <= i_period;
            r_mode_act <= w_in_mode;
            r_started  <= 1'b0;
        end else if (i_tick) begin
            r_carr    <= w_next_carr;
            r_dir     <= w_upd_ev ? w_commit_dir : w_next_dir;
            r_min     <= w_ev_min;
            r_max     <= w_ev_max;
            r_update  <= w_upd_ev;
            r_started <= 1'b1;
            if (w_load_act) begin
                r_per_act  <= i_period;
                r_mode_act <= w_in_mode;
            end
        end else begin
            r_min    <= 1'b0;
            r_max    <= 1'b0;
            r_update <= 1'b0;
            if (!r_started) begin
                r_carr     <= w_held;
                r_dir      <= w_held_dir;
                r_per_act  <= i_period;
                r_mode_act <= w_in_mode;
            end
        end
    end

    // Interrupt decimator: one o_int per i_int_count+1 commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_cnt <= '0;
            r_int     <= 1'b0;
        end else if (i_carr_on == CARR_OFF || i_int_on == INT_OFF) begin
            r_int_cnt <= '0;
            r_int     <= 1'b0;
        end else if (i_tick && w_upd_ev) begin
            if (r_int_cnt == i_int_count) begin
                r_int_cnt <= '0;
                r_int     <= 1'b1;
            end else begin
                r_int_cnt <= r_int_cnt + 1'b1;
                r_int     <= 1'b0;
            end
        end else begin
            r_int <= 1'b0;
        end
    end

    assign o_carr   = r_carr;
    assign o_dir    = r_dir;
    assign o_min    = r_min;
    assign o_max    = r_max;
    assign o_update = r_update;
    assign o_int    = r_int;

endmodule

// File: rtl/pwm_carrier_multi.sv
// Multi-channel PWM carrier generator: a shared clock divider produces the
// tick that advances N_CARR independent carrier channels.
module pwm_carrier_multi #(
    parameter int N_CARR         = 4,
    parameter int PWMCOUNT_WIDTH = pwm_carrier_multi_pkg::PWMCOUNT_WIDTH,
    parameter int DIVCLK_WIDTH   = pwm_carrier_multi_pkg::DIVCLK_WIDTH,
    parameter int INTCOUNT_WIDTH = pwm_carrier_multi_pkg::INTCOUNT_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_clkdiv_on,
    input  logic [DIVCLK_WIDTH-1:0]            i_clkdiv,
    input  logic [N_CARR-1:0]                  i_carr_on,
    input  logic [N_CARR*2-1:0]                i_count_mode,
    input  logic [N_CARR*2-1:0]                i_mask_mode,
    input  logic [N_CARR*PWMCOUNT_WIDTH-1:0]   i_period,
    input  logic [N_CARR*PWMCOUNT_WIDTH-1:0]   i_init,
    input  logic [N_CARR-1:0]                  i_int_on,
    input  logic [INTCOUNT_WIDTH-1:0]          i_int_count,
    output logic [N_CARR*PWMCOUNT_WIDTH-1:0]   o_carr,
    output logic [N_CARR-1:0]                  o_dir,
    output logic [N_CARR-1:0]                  o_min,
    output logic [N_CARR-1:0]                  o_max,
    output logic [N_CARR-1:0]                  o_update,
    output logic [N_CARR-1:0]                  o_int
);

    localparam int W = PWMCOUNT_WIDTH;

    logic [DIVCLK_WIDTH-1:0] r_div_cnt;
    logic                    w_tick;

    assign w_tick = (i_clkdiv_on == pwm_carrier_multi_pkg::CLKDIV_OFF) ||
                    (r_div_cnt == i_clkdiv);

    // Divider counts 0..i_clkdiv and wraps on the tick; held at 0 when off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_CARR; g++) begin : g_chan
        pwm_carrier_chan #(
            .W  (W),
            .IW (INTCOUNT_WIDTH)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_tick       (w_tick),
            .i_carr_on    (i_carr_on[g]),
            .i_count_mode (i_count_mode[g*2 +: 2]),
            .i_mask_mode  (i_mask_mode[g*2 +: 2]),
            .i_period     (i_period[g*W +: W]),
            .i_init       (i_init[g*W +: W]),
            .i_int_on     (i_int_on[g]),
            .i_int_count  (i_int_count),
            .o_carr       (o_carr[g*W +: W]),
            .o_dir        (o_dir[g]),
            .o_min        (o_min[g]),
            .o_max        (o_max[g]),
            .o_update     (o_update[g]),
            .o_int        (o_int[g])
        );
    end

endmodule

// File: tb/tb_pwm_carrier_multi.sv
// Directed bench for pwm_carrier_multi: expected per-channel outputs are
// queued with the stimulus and compared one cycle later after the edge.
module tb_pwm_carrier_multi;
    import pwm_carrier_multi_pkg::*;

    localparam int NC = 4;
    localparam int W  = 16;
    localparam int DW = 5;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_clkdiv_on;
    logic [DW-1:0]   i_clkdiv;
    logic [NC-1:0]   i_carr_on;
    logic [NC*2-1:0] i_count_mode;
    logic [NC*2-1:0] i_mask_mode;
    logic [NC*W-1:0] i_period;
    logic [NC*W-1:0] i_init;
    logic [NC-1:0]   i_int_on;
    logic [IW-1:0]   i_int_count;
    logic [NC*W-1:0] o_carr;
    logic [NC-1:0]   o_dir;
    logic [NC-1:0]   o_min;
    logic [NC-1:0]   o_max;
    logic [NC-1:0]   o_update;
    logic [NC-1:0]   o_int;

    pwm_carrier_multi dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clkdiv_on  (i_clkdiv_on),
        .i_clkdiv     (i_clkdiv),
        .i_carr_on    (i_carr_on),
        .i_count_mode (i_count_mode),
        .i_mask_mode  (i_mask_mode),
        .i_period     (i_period),
        .i_init       (i_init),
        .i_int_on     (i_int_on),
        .i_int_count  (i_int_count),
        .o_carr       (o_carr),
        .o_dir        (o_dir),
        .o_min        (o_min),
        .o_max        (o_max),
        .o_update     (o_update),
        .o_int        (o_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        int             ch;
        logic [W+4:0]   exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic on, input logic [1:0] mode,
                          input logic [1:0] mask, input int per, input int init,
                          input logic int_on);
        i_carr_on[ch]          = on;
        i_count_mode[ch*2 +: 2] = mode;
        i_mask_mode[ch*2 +: 2]  = mask;
        i_period[ch*W +: W]     = W'(per);
        i_init[ch*W +: W]       = W'(init);
        i_int_on[ch]           = int_on;
    endtask

    // flags = {dir, min, max, update, int}
    task automatic exp_ch(input string tag, input int ch, input int carr, input logic [4:0] flags);
        sb_t e;
        e.tag = tag;
        e.ch  = ch;
        e.exp = {W'(carr), flags};
        sb_q.push_back(e);
    endtask

    // Advance one clock edge, then compare every queued expectation.
    task automatic edge_check();
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            sb_t          e;
            logic [W+4:0] obs;
            e   = sb_q.pop_front();
            obs = {o_carr[e.ch*W +: W], o_dir[e.ch], o_min[e.ch], o_max[e.ch],
                   o_update[e.ch], o_int[e.ch]};
            check($sformatf("%s ch%0d (carr,dir,min,max,upd,int)", e.tag, e.ch),
                  64'(obs), 64'(e.exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_clkdiv_on  = 1'b0;
        i_clkdiv     = '0;
        i_carr_on    = '0;
        i_count_mode = '0;
        i_mask_mode  = '0;
        i_period     = '0;
        i_init       = '0;
        i_int_on     = '0;
        i_int_count  = '0;
        set_ch(0, 1'b0, COUNT_UP, NO_MASK, 5, 5, 1'b0);

        // Reset state, with inputs that would otherwise show a nonzero carrier.
        repeat (2) @(posedge clk);
        #1;
        check("reset o_carr",   64'(o_carr),   64'd0);
        check("reset o_dir",    64'(o_dir),    64'd0);
        check("reset o_min",    64'(o_min),    64'd0);
        check("reset o_max",    64'(o_max),    64'd0);
        check("reset o_update", 64'(o_update), 64'd0);
        check("reset o_int",    64'(o_int),    64'd0);
        rst_n = 1'b1;

        // Channels off: carrier holds min(init, period), dir from mode.
        set_ch(0, 1'b0, COUNT_UP,     MINMAX_MASK, 4, 0, 1'b0);
        set_ch(1, 1'b0, COUNT_UPDOWN, NO_MASK,     3, 9, 1'b0);
        set_ch(2, 1'b0, COUNT_DOWN,   MIN_MASK,    7, 2, 1'b0);
        exp_ch("off", 0, 0, 5'b00000);
        exp_ch("off", 1, 3, 5'b00000);
        exp_ch("off", 2, 2, 5'b10000);
        edge_check();

        // Divider 2: ch0 UP P=4 advances every third cycle.
        i_clkdiv    = 5'd2;
        i_clkdiv_on = 1'b1;
        i_carr_on[0] = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            exp_ch($sformatf("div e%0d", e), 0, (e == 15) ? 0 : e / 3,
                   {1'b0, e == 15, e == 12, (e == 12) || (e == 15), 1'b0});
            edge_check();
        end
        i_clkdiv_on = 1'b0;

        // ch0 off again: held value from new init.
        set_ch(0, 1'b0, COUNT_UP, NO_MASK, 10, 6, 1'b0);
        exp_ch("off2", 0, 6, 5'b00000);
        edge_check();

        // ch0 UP NO_MASK: count 7 at P=10, then P=3 forces 0 at the next tick.
        i_carr_on[0] = 1'b1;
        exp_ch("lower", 0, 7, 5'b00010); edge_check();
        i_period[0*W +: W] = 16'd3;
        exp_ch("lower", 0, 0, 5'b01010); edge_check();
        exp_ch("lower", 0, 1, 5'b00010); edge_check();
        exp_ch("lower", 0, 2, 5'b00010); edge_check();
        exp_ch("lower", 0, 3, 5'b00110); edge_check();
        exp_ch("lower", 0, 0, 5'b01010); edge_check();

        // ch1 UPDOWN P=3: triangle 1,2,3,2,1,0,1,2,3.
        set_ch(1, 1'b1, COUNT_UPDOWN, NO_MASK, 3, 0, 1'b0);
        exp_ch("updown", 1, 1, 5'b00010); edge_check();
        exp_ch("updown", 1, 2, 5'b00010); edge_check();
        exp_ch("updown", 1, 3, 5'b10110); edge_check();
        exp_ch("updown", 1, 2, 5'b10010); edge_check();
        exp_ch("updown", 1, 1, 5'b10010); edge_check();
        exp_ch("updown", 1, 0, 5'b01010); edge_check();
        exp_ch("updown", 1, 1, 5'b00010); edge_check();
        exp_ch("updown", 1, 2, 5'b00010); edge_check();
        exp_ch("updown", 1, 3, 5'b10110); edge_check();

        // ch2 DOWN MIN_MASK P=5: new period 2 only committed at the min event.
        set_ch(2, 1'b1, COUNT_DOWN, MIN_MASK, 5, 5, 1'b0);
        exp_ch("minmask", 2, 4, 5'b10000); edge_check();
        exp_ch("minmask", 2, 3, 5'b10000); edge_check();
        i_period[2*W +: W] = 16'd2;
        exp_ch("minmask", 2, 2, 5'b10000); edge_check();
        exp_ch("minmask", 2, 1, 5'b10000); edge_check();
        exp_ch("minmask", 2, 0, 5'b11010); edge_check();
        exp_ch("minmask", 2, 2, 5'b10100); edge_check();
        exp_ch("minmask", 2, 1, 5'b10000); edge_check();
        exp_ch("minmask", 2, 0, 5'b11010); edge_check();

        // ch3 UPDOWN MINMAX P=2, interrupt every third commit; INT_OFF clears.
        i_int_count = 3'd2;
        set_ch(3, 1'b1, COUNT_UPDOWN, MINMAX_MASK, 2, 0, 1'b1);
        for (int e = 1; e <= 22; e++) begin
            int   m;
            logic mn;
            logic mx;
            m  = e % 4;
            mn = (m == 0);
            mx = (m == 2);
            exp_ch($sformatf("int e%0d", e), 3, (m == 2) ? 2 : (m == 0) ? 0 : 1,
                   {(m == 2) || (m == 3), mn, mx, mn | mx,
                    (e == 6) || (e == 12) || (e == 22)});
            edge_check();
            if (e == 14) i_int_on[3] = 1'b0;
            if (e == 16) i_int_on[3] = 1'b1;
        end

        // P=0: carrier stays 0 with min and max on every tick.
        set_ch(1, 1'b1, COUNT_UP, NO_MASK, 0, 0, 1'b0);
        exp_ch("p0", 1, 0, 5'b01110); edge_check();
        exp_ch("p0", 1, 0, 5'b01110); edge_check();
        exp_ch("p0", 1, 0, 5'b01110); edge_check();

        // Asynchronous reset mid-count, then resume from i_init.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset o_carr",   64'(o_carr),   64'd0);
        check("midreset o_dir",    64'(o_dir),    64'd0);
        check("midreset o_min",    64'(o_min),    64'd0);
        check("midreset o_max",    64'(o_max),    64'd0);
        check("midreset o_update", 64'(o_update), 64'd0);
        check("midreset o_int",    64'(o_int),    64'd0);
        i_init[0*W +: W] = 16'd1;
        #3;
        rst_n = 1'b1;
        exp_ch("resume", 0, 2, 5'b00010); edge_check();
        exp_ch("resume", 0, 3, 5'b00110); edge_check();
        exp_ch("resume", 0, 0, 5'b01010); edge_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
